input_matrix_loader: RTL and testbench
======================================

Name: input_matrix_loader

Overview:
- Upstream neighbour of the operand input register bank in the temporal-LUT multiplier / adder-tree datapath.
- Deserialises a narrow valid/ready stream of INPUT_WIDTH elements into one full DIM_ROW x DIM_COL operand frame.
- Presents the frame as a flat packed array with a valid/ready handshake; the downstream register stage captures it.

Parameters:
- DIM_ROW, 2, rows of the operand matrix.
- DIM_COL, 2, columns of the operand matrix.
- INPUT_WIDTH, 8, bits per element.
- LANES, 2, elements accepted per input beat. DIM_ROW*DIM_COL must be divisible by LANES (elaboration-time assertion).
- Derived: N = DIM_ROW*DIM_COL; BEATS = N/LANES; CW = max(1, clog2(BEATS)).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous flush; discards the partial or held frame.
- s_valid  in  1  input beat valid.
- s_ready  out  1  loader can accept a beat.
- s_data  in  [LANES-1:0][INPUT_WIDTH-1:0]  lane k carries element beat_idx*LANES+k.
- m_valid  out  1  full frame available.
- m_ready  in  1  downstream captures the frame.
- m_data  out  [N-1:0][INPUT_WIDTH-1:0]  row-major frame, element r*DIM_COL+c.
- beat_idx  out  CW  current fill position (debug).

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, beat_idx=0, m_valid=0.
  - Frame buffer cleared to 0, so m_data=0.
  - s_ready=1 once rst_n deasserts.
- States:
  - FILL: s_ready=1, m_valid=0.
  - FULL: m_valid=1, s_ready=m_ready (combinational pass-through).
- FILL, beat accepted (s_valid & s_ready):
  - buf[beat_idx*LANES+k] <= s_data[k] for all lanes k.
  - If beat_idx==BEATS-1: beat_idx<=0, state<=FULL; m_valid rises the cycle after the last beat.
  - Otherwise beat_idx++.
- Latency: m_valid rises 1 cycle after the last accepted beat; minimum BEATS cycles per frame.
- FULL, m_ready=0:
  - m_data and m_valid held stable; no beat accepted regardless of s_valid.
- FULL, m_ready=1, no beat: state<=FILL; m_valid falls next cycle.
- FULL, m_ready=1 and s_valid=1 (simultaneous handoff and refill):
  - The frame is consumed at this edge.
  - The beat is written to beat 0; beat_idx<=1 and state<=FILL.
  - If BEATS==1, state stays FULL with the new data, giving full throughput with no bubble.
  - m_data before the edge is the old frame; downstream samples it at the same edge.
- Unaccepted beats: in FILL with s_valid=0, nothing changes; no timeout.
- Element ordering: lane 0 of beat 0 maps to element 0 (row 0, col 0); ordering is strictly ascending.
- clear=1 (priority over all handshakes):
  - Next cycle: state=FILL, beat_idx=0, m_valid=0.
  - Buffer contents retained (not zeroed); any beat presented that cycle is dropped.
  - s_ready is forced to 0 while clear=1.
- Reset mid-frame: immediate async return to reset values; a partial frame is lost.
- m_valid, once high, never drops without m_ready or clear (AXI-style stability). The same holds for m_data.

Optional Feature:
- Macro: INPUT_MATRIX_LOADER_LAST_EN.
- Enabled:
  - Adds input s_last (1 bit) and output frame_err (1 bit, sticky, reset 0, cleared by clear).
  - frame_err sets when an accepted beat has s_last != (beat_idx==BEATS-1).
  - On s_last=1 early, the frame is still closed: state<=FULL and beat_idx<=0; elements not yet written keep their stale values.
  - A missing s_last on the final beat flags the error but the frame completes normally.
- Disabled: no s_last or frame_err ports; frames are delimited purely by beat count.

Test Plan:
- Reset: assert rst_n=0 mid-fill -> m_valid=0, beat_idx=0, m_data=0, s_ready=1 after release.
- Basic fill (2x2, W=8, LANES=2): beats {0x11,0x22} then {0x33,0x44}, m_ready=1 -> m_valid high 1 cycle after beat 2; m_data[0..3]=11,22,33,44.
- Backpressure: m_ready=0 for 5 cycles with s_valid=1 -> s_ready=0 throughout; m_data stable; next frame starts only after m_ready.
- Back-to-back: continuous s_valid with m_ready=1 -> handoff cycle accepts beat 0 of the next frame; one frame per 2 cycles, no beat lost or duplicated.
- Clear: after 1 of 2 beats, pulse clear, then send {0xA0,0xA1},{0xA2,0xA3} -> frame = A0,A1,A2,A3; no mixing with the dropped beat.
- LAST_EN: s_last=1 on beat 0 -> frame_err=1 and held until clear; m_valid asserts the next cycle.

Source files
------------

// File: rtl/input_matrix_loader.sv
// Deserialises a LANES-wide element stream into one DIM_ROW x DIM_COL operand frame.
// Optional s_last framing check is compiled in with INPUT_MATRIX_LOADER_LAST_EN.
module input_matrix_loader #(
    parameter int DIM_ROW     = 2,
    parameter int DIM_COL     = 2,
    parameter int INPUT_WIDTH = 8,
    parameter int LANES       = 2,
    localparam int N          = DIM_ROW * DIM_COL,
    localparam int BEATS      = N / LANES,
    localparam int CW         = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 clear,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [LANES-1:0][INPUT_WIDTH-1:0]    s_data,
`ifdef INPUT_MATRIX_LOADER_LAST_EN
    input  logic                                 s_last,
    output logic                                 frame_err,
`endif
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [N-1:0][INPUT_WIDTH-1:0]        m_data,
    output logic [CW-1:0]                        beat_idx
);

    localparam int EW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((N % LANES) != 0) begin : g_bad_lanes
            $error("input_matrix_loader: DIM_ROW*DIM_COL must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t                          state;
    logic [N-1:0][INPUT_WIDTH-1:0]   frame_q;
    logic                            accept;
    logic [CW-1:0]                   wr_idx;
    logic                            wr_last;
    logic                            close_frame;

    // Valid/ready: a beat transfers on any edge where s_valid & s_ready; a frame
    // transfers on any edge where m_valid & m_ready. In FULL the loader accepts
    // a new beat only on the edge that hands the held frame downstream.
    assign s_ready = !clear && ((state == FILL) || m_ready);
    assign accept  = s_valid && s_ready;

    // A beat accepted during handoff always starts the next frame at beat 0.
    assign wr_idx  = (state == FULL) ? '0 : beat_idx;
    assign wr_last = (wr_idx == CW'(BEATS - 1));

`ifdef INPUT_MATRIX_LOADER_LAST_EN
    assign close_frame = wr_last || s_last;
`else
    assign close_frame = wr_last;
`endif

    assign m_data = frame_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FILL;
            beat_idx <= '0;
            m_valid  <= 1'b0;
            frame_q  <= '0;
`ifdef INPUT_MATRIX_LOADER_LAST_EN
            frame_err <= 1'b0;
`endif
        end else if (clear) begin
            // Buffer contents intentionally survive a flush.
            state    <= FILL;
            beat_idx <= '0;
            m_valid  <= 1'b0;
`ifdef INPUT_MATRIX_LOADER_LAST_EN
            frame_err <= 1'b0;
`endif
        end else if (accept) begin
            for (int k = 0; k < LANES; k++) begin
                frame_q[EW'(int'(wr_idx) * LANES + k)] <= s_data[k];
            end
            if (close_frame) begin
                state    <= FULL;
                m_valid  <= 1'b1;
                beat_idx <= '0;
            end else begin
                state    <= FILL;
                m_valid  <= 1'b0;
                beat_idx <= wr_idx + CW'(1);
            end
`ifdef INPUT_MATRIX_LOADER_LAST_EN
            if (s_last != wr_last) begin
                frame_err <= 1'b1;
            end
`endif
        end else if ((state == FULL) && m_ready) begin
            state   <= FILL;
            m_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    a_valid_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready && !clear) |=> m_valid);
    a_data_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready && !clear) |=> $stable(m_data));
    a_no_ready_on_clear : assert property (@(posedge clk) disable iff (!rst_n)
        clear |-> !s_ready);
`endif

endmodule

// File: tb/tb_input_matrix_loader.sv
// Self-checking bench for input_matrix_loader: directed vectors, corner-case
// sequences and randomized traffic scored against a frame-level model.
module tb_input_matrix_loader;

    localparam int DIM_ROW = 2;
    localparam int DIM_COL = 2;
    localparam int W       = 8;
    localparam int LANES   = 2;
    localparam int N       = DIM_ROW * DIM_COL;
    localparam int BEATS   = N / LANES;
    localparam int CW      = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic                     clk;
    logic                     rst_n;
    logic                     clear;
    logic                     s_valid;
    logic                     s_ready;
    logic [LANES-1:0][W-1:0]  s_data;
    logic                     m_valid;
    logic                     m_ready;
    logic [N-1:0][W-1:0]      m_data;
    logic [CW-1:0]            beat_idx;
`ifdef INPUT_MATRIX_LOADER_LAST_EN
    logic                     s_last;
    logic                     frame_err;
`endif

    input_matrix_loader #(
        .DIM_ROW(DIM_ROW), .DIM_COL(DIM_COL), .INPUT_WIDTH(W), .LANES(LANES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
`ifdef INPUT_MATRIX_LOADER_LAST_EN
        .s_last(s_last), .frame_err(frame_err),
`endif
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .beat_idx(beat_idx)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: element memory, fill count, queue of completed frames
    logic [N*W-1:0] exp_q[$];
    logic [W-1:0]   mem[N];
    int             cnt = 0;
    int             frames_out = 0;
    logic           err_m = 1'b0;
    logic           force_last = 1'b0;

    task automatic model_reset();
        exp_q.delete();
        cnt = 0;
        err_m = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
    endtask

    always @(negedge clk) begin : mon
        logic           ev;
        logic           er;
        logic           lp;
        logic           cl;
        logic [N*W-1:0] f;
        if (rst_n) begin
            ev = (exp_q.size() > 0);
            er = !clear && (!ev || m_ready);
            chk("m_valid", 64'(m_valid), 64'(ev));
            chk("s_ready", 64'(s_ready), 64'(er));
`ifdef INPUT_MATRIX_LOADER_LAST_EN
            chk("frame_err", 64'(frame_err), 64'(err_m));
`endif
            if (clear) begin
                exp_q.delete();
                cnt = 0;
                err_m = 1'b0;
            end else begin
                if (ev && m_ready) begin
                    chk("frame", 64'(m_data), 64'(exp_q.pop_front()));
                    frames_out++;
                end
                if (s_valid && er) begin
                    for (int k = 0; k < LANES; k++) mem[cnt + k] = s_data[k];
                    lp = (cnt + LANES == N);
                    cl = lp;
`ifdef INPUT_MATRIX_LOADER_LAST_EN
                    cl = lp || s_last;
                    if (s_last != lp) err_m = 1'b1;
`endif
                    cnt += LANES;
                    if (cl) begin
                        for (int i = 0; i < N; i++) f[i*W +: W] = mem[i];
                        exp_q.push_back(f);
                        cnt = 0;
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_last();
`ifdef INPUT_MATRIX_LOADER_LAST_EN
        s_last = force_last || (cnt + LANES == N);
`endif
    endtask

    task automatic send_beat(input logic [LANES*W-1:0] d);
        logic acc;
        int   n;
        s_valid = 1'b1;
        s_data  = d;
        set_last();
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = s_ready;
            step();
            n++;
        end
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: beat %0h not accepted in %0d cycles", d, n);
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    typedef struct {
        logic [LANES*W-1:0] b0;
        logic [LANES*W-1:0] b1;
        logic [N*W-1:0]     exp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{16'h2211, 16'h4433, 32'h44332211};
        vecs[1] = '{16'h0000, 16'hFFFF, 32'hFFFF0000};
        vecs[2] = '{16'hFF00, 16'h00FF, 32'h00FFFF00};
        vecs[3] = '{16'h1234, 16'h5678, 32'h56781234};

        rst_n = 1'b0; clear = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
`ifdef INPUT_MATRIX_LOADER_LAST_EN
        s_last = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_beat_idx", 64'(beat_idx), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd1);

        // basic fill
        m_ready = 1'b1;
        send_beat(16'h2211);
        chk("basic_idx1", 64'(beat_idx), 64'd1);
        chk("basic_not_valid", 64'(m_valid), 64'd0);
        send_beat(16'h4433);
        chk("basic_valid", 64'(m_valid), 64'd1);
        chk("basic_data", 64'(m_data), 64'h44332211);
        chk("basic_idx0", 64'(beat_idx), 64'd0);
        step();
        chk("basic_consumed", 64'(m_valid), 64'd0);

        // reset mid-frame
        m_ready = 1'b0;
        send_beat(16'h7788);
        chk("mid_idx", 64'(beat_idx), 64'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_beat_idx", 64'(beat_idx), 64'd0);
        chk("midrst_m_data", 64'(m_data), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_s_ready", 64'(s_ready), 64'd1);

        // backpressure
        m_ready = 1'b0;
        send_beat(16'h0201);
        send_beat(16'h0403);
        chk("bp_valid", 64'(m_valid), 64'd1);
        s_valid = 1'b1;
        s_data = 16'hEEEE;
        set_last();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_s_ready", 64'(s_ready), 64'd0);
            chk("bp_data_hold", 64'(m_data), 64'h04030201);
            step();
        end
        m_ready = 1'b1;
        send_beat(16'h0605);
        send_beat(16'h0807);
        chk("bp_next_frame", 64'(m_data), 64'h08070605);
        step();

        // back-to-back at full rate
        begin
            int f0;
            f0 = frames_out;
            m_ready = 1'b1;
            s_valid = 1'b1;
            for (int i = 0; i < 20; i++) begin
                s_data = LANES*W'($urandom);
                set_last();
                @(negedge clk);
                chk("b2b_ready", 64'(s_ready), 64'd1);
                step();
            end
            s_valid = 1'b0;
            step();
            step();
            chk("b2b_frames", 64'(frames_out - f0), 64'(20 / BEATS));
        end

        // clear after a partial frame
        m_ready = 1'b0;
        send_beat(16'hBBAA);
        clear = 1'b1;
        s_valid = 1'b1;
        s_data = 16'hCCCC;
        @(negedge clk);
        chk("clr_s_ready", 64'(s_ready), 64'd0);
        step();
        clear = 1'b0;
        s_valid = 1'b0;
        chk("clr_idx", 64'(beat_idx), 64'd0);
        chk("clr_m_valid", 64'(m_valid), 64'd0);
        send_beat(16'hA1A0);
        send_beat(16'hA3A2);
        chk("clr_frame_valid", 64'(m_valid), 64'd1);
        chk("clr_frame_data", 64'(m_data), 64'hA3A2A1A0);
        pulse_clear();
        chk("clr_held_drop", 64'(m_valid), 64'd0);

        // table-driven vectors
        foreach (vecs[i]) begin
            m_ready = 1'b0;
            send_beat(vecs[i].b0);
            send_beat(vecs[i].b1);
            chk("vec_valid", 64'(m_valid), 64'd1);
            chk("vec_data", 64'(m_data), 64'(vecs[i].exp));
            m_ready = 1'b1;
            step();
            m_ready = 1'b0;
            chk("vec_drain", 64'(m_valid), 64'd0);
        end

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = LANES*W'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
            clear   = ($urandom_range(0, 29) == 0);
            set_last();
`ifdef INPUT_MATRIX_LOADER_LAST_EN
            if ($urandom_range(0, 15) == 0) s_last = !s_last;
`endif
            step();
        end
        s_valid = 1'b0;
        clear = 1'b0;
        m_ready = 1'b1;
        repeat (3) step();
        chk("rand_drained", 64'(exp_q.size()), 64'd0);

`ifdef INPUT_MATRIX_LOADER_LAST_EN
        pulse_clear();
        m_ready = 1'b1;
        send_beat(16'h2211);
        send_beat(16'h4433);
        step();
        pulse_clear();
        m_ready = 1'b0;
        force_last = 1'b1;
        send_beat(16'h6655);
        force_last = 1'b0;
        chk("last_err", 64'(frame_err), 64'd1);
        chk("last_valid", 64'(m_valid), 64'd1);
        chk("last_stale", 64'(m_data), 64'h44336655);
        m_ready = 1'b1;
        step();
        step();
        chk("last_sticky", 64'(frame_err), 64'd1);
        pulse_clear();
        chk("last_cleared", 64'(frame_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
